// File: rtl/mean_recip_ctrl.sv
// mean_recip_ctrl
// Windowed mean unit on the requesting side of the shared reciprocal LUT mux.
// It accumulates 1..4 unsigned samples. It then drives recip_sel = 4-n so the
// mux returns the Q2.30 value of 1/n. It scales the window sum by that value and
// presents the rounded mean on a valid/ready output.
//
// Select encoding owned here: sel 0 -> n=4, 1 -> n=3, 2 -> n=2, 3 -> n=1,
// 4 -> idle (the mux returns 0 for this select).
//
// Optional build macro: MEAN_INTERNAL_LUT_EN
//   When defined, recip_val is ignored and the reciprocal constants are
//   generated internally. recip_sel is still driven exactly as in the
//   default build.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   in_valid   input sample valid
//   in_data    unsigned input sample (DATA_W)
//   in_last    closes the window; qualified by in_valid
//   in_ready   a sample is accepted this cycle
//   recip_sel  select to the reciprocal LUT mux (3 bits)
//   recip_val  reciprocal returned by the mux, Q2.30
//   out_valid  mean available
//   out_data   rounded mean (DATA_W)
//   out_count  number of samples in the window (1..4)
//   out_ready  downstream accepts the mean
module mean_recip_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [2:0]        recip_sel,
  input  logic [31:0]       recip_val,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_count,
  input  logic              out_ready
);

  localparam int unsigned SUM_W   = DATA_W + 2;
  localparam int unsigned RECIP_W = 32;
  // One spare bit so that adding the rounding constant can never wrap.
  localparam int unsigned PROD_W  = SUM_W + RECIP_W + 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCALE   = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [SUM_W-1:0]    sum, sum_nx;
  logic [2:0]          n, n_nx;
  logic [RECIP_W-1:0]  recip;
  logic [PROD_W-1:0]   prod_rnd;
  logic [DATA_W-1:0]   mean;

  // Reciprocal source for the SCALE cycle.
`ifdef MEAN_INTERNAL_LUT_EN
  logic unused_recip;
  assign unused_recip = ^recip_val;

  always_comb begin
    case (n)
      3'd1:    recip = 32'h4000_0000;
      3'd2:    recip = 32'h2000_0000;
      3'd3:    recip = 32'h1555_5555;
      default: recip = 32'h1000_0000;
    endcase
  end
`else
  assign recip = recip_val;
`endif

  // Full-width product, then round half up into the integer part.
  always_comb begin
    prod_rnd = PROD_W'(sum) * PROD_W'(recip) + (PROD_W'(1) << (FRAC_BITS - 1));
    mean     = DATA_W'(prod_rnd >> FRAC_BITS);
  end

  // Next-state and accumulator update.
  always_comb begin
    state_nx = state;
    sum_nx   = sum;
    n_nx     = n;
    case (state)
      COLLECT: begin
        if (in_valid) begin
          sum_nx = sum + SUM_W'(in_data);
          n_nx   = n + 3'd1;
          // A 4th sample closes the window whether or not in_last is set.
          if (in_last || (n_nx == 3'd4)) begin
            state_nx = SCALE;
          end
        end
      end
      SCALE: begin
        sum_nx   = '0;
        n_nx     = '0;
        state_nx = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_nx = COLLECT;
        end
      end
      default: begin
        sum_nx   = '0;
        n_nx     = '0;
        state_nx = COLLECT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and registered outputs. The handshake flags and recip_sel are
  // decoded from the next state, so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      n         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      recip_sel <= 3'd4;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      sum       <= sum_nx;
      n         <= n_nx;
      in_ready  <= (state_nx == COLLECT);
      out_valid <= (state_nx == OUT);
      recip_sel <= (state_nx == SCALE) ? 3'(3'd4 - n_nx) : 3'd4;
      if (state == SCALE) begin
        out_data  <= mean;
        out_count <= n;
      end
    end
  end

endmodule
